// File: rtl/knn_result_axis_tx_pkg.sv
// knn_pkg: shared types for the KNN result AXI-Stream transmitter.
// Result values are stored zero-extended to the stream width so one entry type serves every DATA_WIDTH.
package knn_pkg;

    localparam int AXIS_TDATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NAME  = 2'd1,
        VALUE = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [31:0]             name;
        logic [AXIS_TDATA_W-1:0] value;
    } res_entry_t;

endpackage

// File: rtl/knn_result_axis_tx_if.sv
// knn_result_axis_tx_if: AXI-Stream link from the result transmitter toward the DMA.
interface knn_result_axis_tx_if;
    import knn_pkg::*;

    logic [AXIS_TDATA_W-1:0] tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/knn_result_axis_tx_fifo.sv
// knn_result_fifo: synchronous result FIFO; pointers carry one extra wrap bit to tell full from empty.
// Exposes the head entry and the one behind it so back-to-back results need no idle cycle.
module knn_result_fifo
    import knn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       push,
    input  res_entry_t push_data,
    input  logic       pop,
    output res_entry_t head,
    output res_entry_t second,
    output logic       full,
    output logic       empty,
    output logic       empty_next,
    output logic [AW:0] count
);
    localparam int PW = AW + 1;

    res_entry_t    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [AW-1:0] rd_addr_second;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign rd_addr_second = rd_ptr[AW-1:0] + 1'b1;
    assign head           = mem[rd_ptr[AW-1:0]];
    assign second         = mem[rd_addr_second];

    always_comb begin
        wr_ptr_d = wr_ptr + PW'(push);
        rd_ptr_d = rd_ptr + PW'(pop && !empty);
    end

    assign empty_next = (wr_ptr_d == rd_ptr_d);

    always_ff @(posedge mclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge mclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/knn_result_axis_tx.sv
// knn_result_axis_tx: buffers sorter result strobes and sends each as a name beat then a value beat.
// Optional macro KNN_TX_OVERFLOW_FLAG_EN adds a sticky `overflow` output flagging dropped results.
module knn_result_axis_tx
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  res_wr_en,
    input  logic [31:0]           res_name,
    input  logic [DATA_WIDTH-1:0] res_value,
    knn_result_axis_tx_if.master  m_axis,
    output logic                  busy
`ifdef KNN_TX_OVERFLOW_FLAG_EN
    ,
    output logic                  overflow
`endif
);
    localparam int GW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(K - 1);
    localparam logic [AW:0]   ONE      = 1;

    tx_state_t               state, state_d;
    logic [AXIS_TDATA_W-1:0] tdata_q, tdata_d;
    logic                    tlast_q, tlast_d, tvalid_q, busy_q;
    logic [GW-1:0]           grp_cnt, grp_cnt_d;
    logic                    hs, pop, push, full, empty, empty_next;
    logic [AW:0]             count;
    res_entry_t              push_data, head, second;

    assign hs = tvalid_q && m_axis.tready;
    // A full FIFO still takes a result when the value beat retires in the same cycle.
    assign push      = res_wr_en && (!full || pop);
    assign push_data = '{name: res_name, value: AXIS_TDATA_W'(res_value)};

    knn_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .mclk       (mclk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .second     (second),
        .full       (full),
        .empty      (empty),
        .empty_next (empty_next),
        .count      (count)
    );

    always_ff @(posedge mclk) begin
        if (!reset) begin
            state    <= IDLE;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            grp_cnt  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= (state_d != IDLE);
            grp_cnt  <= grp_cnt_d;
            busy_q   <= !empty_next || (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (!empty) state_d = NAME;
            NAME:    if (hs) state_d = VALUE;
            VALUE:   if (hs) state_d = (count > ONE) ? NAME : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        grp_cnt_d = grp_cnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    tdata_d = head.name;
                    tlast_d = 1'b0;
                end
            end
            NAME: begin
                if (hs) begin
                    tdata_d = head.value;
                    tlast_d = (grp_cnt == GRP_LAST);
                end
            end
            VALUE: begin
                if (hs) begin
                    pop       = 1'b1;
                    tlast_d   = 1'b0;
                    grp_cnt_d = (grp_cnt == GRP_LAST) ? '0 : grp_cnt + 1'b1;
                    // The entry behind the head becomes the new head once this pop lands.
                    if (count > ONE) tdata_d = second.name;
                end
            end
            default: ;
        endcase
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;

`ifdef KNN_TX_OVERFLOW_FLAG_EN
    always_ff @(posedge mclk) begin
        if (!reset) overflow <= 1'b0;
        else if (res_wr_en && !push) overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_knn_result_axis_tx.sv
// Bench for knn_result_axis_tx: three instances (K=1,2,3) share one stimulus; a transaction-level
// model predicts each instance's beat stream. Build with KNN_TX_OVERFLOW_FLAG_EN to cover `overflow`.
module tb_knn_result_axis_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NI    = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic          mclk      = 1'b0;
    logic          reset     = 1'b0;
    logic          res_wr_en = 1'b0;
    logic          tready    = 1'b0;
    logic [31:0]   res_name  = '0;
    logic [DW-1:0] res_value = '0;

    logic [31:0] tdata  [NI];
    logic        tvalid [NI];
    logic        tlast  [NI];
    logic        busy   [NI];
`ifdef KNN_TX_OVERFLOW_FLAG_EN
    logic        ovf    [NI];
`endif

    int n_pass  = 0;
    int n_total = 0;

    beat_t cap   [NI][$];
    beat_t exp_q [NI][$];

    always #5 mclk = ~mclk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        knn_result_axis_tx_if axis ();
        assign axis.tready = tready;
        assign tdata[g]    = axis.tdata;
        assign tvalid[g]   = axis.tvalid;
        assign tlast[g]    = axis.tlast;

        knn_result_axis_tx #(.DATA_WIDTH(DW), .K(g + 1), .FIFO_DEPTH(DEPTH)) dut (
            .mclk      (mclk),
            .reset     (reset),
            .res_wr_en (res_wr_en),
            .res_name  (res_name),
            .res_value (res_value),
            .m_axis    (axis),
            .busy      (busy[g])
`ifdef KNN_TX_OVERFLOW_FLAG_EN
            ,
            .overflow  (ovf[g])
`endif
        );
    end

    // Reference model: results are accepted while fewer than DEPTH are outstanding, or when a
    // result retires on the same edge; each accepted result yields a name beat then a value beat,
    // with tlast on the value beat closing every K-th result since reset.
    int occ;
    bit value_next;
    bit pop_now;
    bit drop_seen;
    int grp [NI];

    always @(negedge mclk) begin
        if (!reset) begin
            occ        = 0;
            value_next = 1'b0;
            drop_seen  = 1'b0;
            for (int i = 0; i < NI; i++) grp[i] = 0;
        end else begin
            pop_now = 1'b0;
            if (tvalid[0] && tready) begin
                pop_now    = value_next;
                value_next = ~value_next;
            end
            for (int i = 0; i < NI; i++)
                if (tvalid[i] && tready) cap[i].push_back('{data: tdata[i], last: tlast[i]});
            if (res_wr_en) begin
                if (occ < DEPTH || pop_now) begin
                    occ++;
                    for (int i = 0; i < NI; i++) begin
                        exp_q[i].push_back('{data: res_name, last: 1'b0});
                        exp_q[i].push_back('{data: 32'(res_value), last: (grp[i] == i)});
                        grp[i] = (grp[i] + 1) % (i + 1);
                    end
                end else begin
                    drop_seen = 1'b1;
                end
            end
            if (pop_now) occ--;
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic strobe(input logic [31:0] nm, input logic [DW-1:0] val);
        res_wr_en = 1'b1;
        res_name  = nm;
        res_value = val;
        tick();
        res_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        res_wr_en = 1'b0;
        reset     = 1'b0;
        tick();
        reset     = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c      = 0;
        tready = 1'b1;
        while ((busy[0] || busy[1] || busy[2] || tvalid[0]) && c < budget) begin
            tick();
            c++;
        end
        check("idle_within_budget", 32'(c < budget), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int c;
        c = 0;
        while (!tvalid[0] && c < budget) begin
            tick();
            c++;
        end
        check("valid_within_budget", 32'(tvalid[0]), 32'd1);
    endtask

    task automatic compare_streams(input bit partial);
        for (int i = 0; i < NI; i++) begin
            int n;
            if (partial)
                check($sformatf("k%0d_prefix_len", i + 1),
                      32'(cap[i].size() <= exp_q[i].size()), 32'd1);
            else
                check($sformatf("k%0d_beat_count", i + 1), 32'(cap[i].size()), 32'(exp_q[i].size()));
            n = (cap[i].size() < exp_q[i].size()) ? cap[i].size() : exp_q[i].size();
            for (int j = 0; j < n; j++) begin
                check($sformatf("k%0d_beat%0d_data", i + 1, j), cap[i][j].data, exp_q[i][j].data);
                check($sformatf("k%0d_beat%0d_last", i + 1, j),
                      32'(cap[i][j].last), 32'(exp_q[i][j].last));
            end
            cap[i].delete();
            exp_q[i].delete();
        end
    endtask

    initial begin
        logic [31:0]   nm;
        logic [DW-1:0] val;

        // Reset state
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_rst_tvalid", i + 1), 32'(tvalid[i]), 32'd0);
            check($sformatf("k%0d_rst_tlast", i + 1), 32'(tlast[i]), 32'd0);
            check($sformatf("k%0d_rst_tdata", i + 1), tdata[i], 32'd0);
            check($sformatf("k%0d_rst_busy", i + 1), 32'(busy[i]), 32'd0);
`ifdef KNN_TX_OVERFLOW_FLAG_EN
            check($sformatf("k%0d_rst_overflow", i + 1), 32'(ovf[i]), 32'd0);
`endif
        end
        reset  = 1'b1;
        tready = 1'b1;
        tick();

        // Single result latency: strobe in cycle n, name beat at n+2, value at n+3, idle at n+4
        strobe(32'd5, DW'(16'h0010));
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_n1_tvalid", i + 1), 32'(tvalid[i]), 32'd0);
            check($sformatf("k%0d_n1_busy", i + 1), 32'(busy[i]), 32'd1);
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_n2_tvalid", i + 1), 32'(tvalid[i]), 32'd1);
            check($sformatf("k%0d_n2_tdata", i + 1), tdata[i], 32'h5);
            check($sformatf("k%0d_n2_tlast", i + 1), 32'(tlast[i]), 32'd0);
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_n3_tvalid", i + 1), 32'(tvalid[i]), 32'd1);
            check($sformatf("k%0d_n3_tdata", i + 1), tdata[i], 32'h10);
            check($sformatf("k%0d_n3_tlast", i + 1), 32'(tlast[i]), (i == 0) ? 32'd1 : 32'd0);
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_n4_tvalid", i + 1), 32'(tvalid[i]), 32'd0);
            check($sformatf("k%0d_n4_busy", i + 1), 32'(busy[i]), 32'd0);
        end
        compare_streams(1'b0);

        // Groups: names 1,2,3 then a fourth result opening a new group
        do_reset();
        for (int k = 1; k <= 4; k++) strobe(32'(k), DW'($urandom));
        wait_idle(100);
        compare_streams(1'b0);

        // Backpressure on a name beat for five cycles
        nm  = $urandom;
        val = DW'($urandom);
        tready = 1'b0;
        strobe(nm, val);
        wait_valid(20);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_tvalid", 32'(tvalid[0]), 32'd1);
            check("bp_hold_tdata", tdata[0], nm);
            check("bp_hold_tlast", 32'(tlast[0]), 32'd0);
        end
        tready = 1'b1;
        tick();
        check("bp_release_value_beat", tdata[0], 32'(val));
        wait_idle(100);
        compare_streams(1'b0);

        // Overflow: six strobes into a depth-4 FIFO with the sink stalled
        do_reset();
        tready = 1'b0;
        for (int k = 0; k < 6; k++) strobe($urandom, DW'($urandom));
        tick();
        tick();
`ifdef KNN_TX_OVERFLOW_FLAG_EN
        for (int i = 0; i < NI; i++) check($sformatf("k%0d_overflow_set", i + 1), 32'(ovf[i]), 32'd1);
`endif
        wait_idle(100);
        check("ovf_kept_four_results", 32'(cap[0].size()), 32'd8);
        compare_streams(1'b0);

        // Full FIFO: strobe lands on the same edge as the value-beat handshake
        do_reset();
        tready = 1'b0;
        val = DW'($urandom);
        strobe($urandom, val);
        for (int k = 0; k < 3; k++) strobe($urandom, DW'($urandom));
        wait_valid(20);
        tready = 1'b1;
        tick();
        check("full_pushpop_value_beat", tdata[0], 32'(val));
        strobe($urandom, DW'($urandom));
        wait_idle(100);
        check("full_pushpop_five_results", 32'(cap[0].size()), 32'd10);
`ifdef KNN_TX_OVERFLOW_FLAG_EN
        check("full_pushpop_no_overflow", 32'(ovf[0]), 32'd0);
`endif
        compare_streams(1'b0);

        // Reset for one cycle mid-group, after the first value beat; strobe during reset ignored
        do_reset();
        tready = 1'b1;
        strobe($urandom, DW'($urandom));
        strobe($urandom, DW'($urandom));
        tick();
        tick();
        compare_streams(1'b1);
        reset     = 1'b0;
        res_wr_en = 1'b1;
        res_name  = $urandom;
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("k%0d_midrst_tvalid", i + 1), 32'(tvalid[i]), 32'd0);
            check($sformatf("k%0d_midrst_busy", i + 1), 32'(busy[i]), 32'd0);
        end
        reset     = 1'b1;
        res_wr_en = 1'b0;
        tick();
        check("midrst_strobe_ignored", 32'(busy[0]), 32'd0);
        strobe($urandom, DW'($urandom));
        strobe($urandom, DW'($urandom));
        wait_idle(100);
        check("midrst_k2_first_value_tlast",
              (cap[1].size() >= 2) ? 32'(cap[1][1].last) : 32'hxxxx_xxxx, 32'd0);
        compare_streams(1'b0);

        // Randomised strobes and sink stalls
        do_reset();
        for (int c = 0; c < 300; c++) begin
            res_wr_en = ($urandom_range(0, 2) != 0);
            res_name  = $urandom;
            res_value = DW'($urandom);
            tready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        res_wr_en = 1'b0;
        wait_idle(200);
`ifdef KNN_TX_OVERFLOW_FLAG_EN
        for (int i = 0; i < NI; i++)
            check($sformatf("k%0d_rand_overflow", i + 1), 32'(ovf[i]), 32'(drop_seen));
`endif
        compare_streams(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
